// File: rtl/alarm_tone_driver_if.sv
// alarm_tone_driver_if: buzzer request/control inputs and tone/status outputs of the alarm tone driver.
interface alarm_tone_driver_if #(parameter int CW = 8);
    logic [2:0]    buzz_in;
    logic          mute;
    logic          clr_cnt;
    logic          tone_out;
    logic [1:0]    active;
    logic [CW-1:0] event_cnt1;
    logic [CW-1:0] event_cnt2;
    logic [CW-1:0] event_cnt3;
    modport master (
        output buzz_in, mute, clr_cnt,
        input  tone_out, active, event_cnt1, event_cnt2, event_cnt3
    );
    modport slave (
        input  buzz_in, mute, clr_cnt,
        output tone_out, active, event_cnt1, event_cnt2, event_cnt3
    );
endinterface

// File: rtl/alarm_tone_driver.sv
// alarm_tone_driver: turns the highest-priority buzzer level into a cadenced square-wave tone
// and keeps saturating per-channel alarm-event counters.
module alarm_tone_driver #(
    parameter int DIV1    = 50,
    parameter int DIV2    = 100,
    parameter int DIV3    = 200,
    parameter int ON_CYC  = 64,
    parameter int OFF_CYC = 32,
    parameter int CW      = 8
) (
    input logic clk,
    input logic reset,
    alarm_tone_driver_if.slave bus
);
    localparam int DMAX = (DIV1 > DIV2) ? ((DIV1 > DIV3) ? DIV1 : DIV3) : ((DIV2 > DIV3) ? DIV2 : DIV3);
    localparam int CMAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int DW   = $clog2(DMAX + 1);
    localparam int KW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t        state, state_n;
    logic [1:0]    act, act_n, sel;
    logic          tone, tone_n, held, go;
    logic [DW-1:0] div_cnt, div_n, div_top;
    logic [KW-1:0] cad_cnt, cad_n;
    logic [2:0]    buzz_prev, rise;
    logic [CW-1:0] cnt [3];

    assign sel = bus.buzz_in[2] ? 2'd3 : bus.buzz_in[1] ? 2'd2 : bus.buzz_in[0] ? 2'd1 : 2'd0;
    // act==0 shifts the mask out entirely, so IDLE never counts as holding a channel
    assign held = |(bus.buzz_in & (3'b001 << (act - 2'd1)));
    assign div_top = (act == 2'd3) ? DW'(DIV3 - 1) : (act == 2'd2) ? DW'(DIV2 - 1) : DW'(DIV1 - 1);

    always_comb begin
        state_n = state;
        act_n   = act;
        tone_n  = tone;
        div_n   = div_cnt;
        cad_n   = cad_cnt;
        go      = 1'b0;
        if (bus.mute || !held) begin
            state_n = IDLE;
            act_n   = 2'd0;
            tone_n  = 1'b0;
            div_n   = '0;
            cad_n   = '0;
            go      = !bus.mute && |bus.buzz_in;
        end else if (sel > act) begin
            go = 1'b1;
        end else if (state == ON) begin
            if (cad_cnt == KW'(ON_CYC - 1)) begin
                state_n = OFF;
                tone_n  = 1'b0;
                div_n   = '0;
                cad_n   = '0;
            end else begin
                cad_n  = cad_cnt + 1'b1;
                div_n  = (div_cnt == div_top) ? '0 : div_cnt + 1'b1;
                tone_n = (div_cnt == div_top) ? ~tone : tone;
            end
        end else if (cad_cnt == KW'(OFF_CYC - 1)) begin
            go = 1'b1;
        end else begin
            cad_n = cad_cnt + 1'b1;
        end
        if (go) begin
            state_n = ON;
            act_n   = sel;
            tone_n  = 1'b1;
            div_n   = '0;
            cad_n   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            act     <= 2'd0;
            tone    <= 1'b0;
            div_cnt <= '0;
            cad_cnt <= '0;
        end else begin
            state   <= state_n;
            act     <= act_n;
            tone    <= tone_n;
            div_cnt <= div_n;
            cad_cnt <= cad_n;
        end
    end

    assign rise = bus.buzz_in & ~buzz_prev;

    // clear wins over a coincident rising edge; counts stick at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buzz_prev <= 3'b000;
            cnt       <= '{default: '0};
        end else begin
            buzz_prev <= bus.buzz_in;
            for (int i = 0; i < 3; i++)
                if (bus.clr_cnt) cnt[i] <= '0;
                else if (rise[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
        end
    end

    assign bus.tone_out   = tone;
    assign bus.active     = act;
    assign bus.event_cnt1 = cnt[0];
    assign bus.event_cnt2 = cnt[1];
    assign bus.event_cnt3 = cnt[2];
endmodule

// File: tb/tb_alarm_tone_driver.sv
// tb_alarm_tone_driver: directed scoreboard bench for alarm_tone_driver with small dividers and CW=3.
module tb_alarm_tone_driver;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alarm_tone_driver_if #(.CW(3)) bus();

    alarm_tone_driver #(
        .DIV1(2), .DIV2(3), .DIV3(4), .ON_CYC(8), .OFF_CYC(4), .CW(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        string      tag;
        bit         is_cnt;
        logic [8:0] v;
    } exp_t;

    exp_t sb[$];
    int npass = 0;
    int nchk  = 0;

    // hand-derived tone sequences, bit i = tone_out after the i-th edge
    logic [11:0] basic = 12'h033;
    logic [4:0]  dropp = 5'b00111;
    logic [5:0]  pre   = 6'b001111;

    task automatic compare();
        exp_t e;
        logic [8:0] o;
        e = sb.pop_front();
        o = e.is_cnt ? {bus.event_cnt1, bus.event_cnt2, bus.event_cnt3}
                     : {6'b0, bus.tone_out, bus.active};
        nchk++;
        assert (o === e.v) npass++;
        else $error("FAIL %s: observed %h expected %h", e.tag, o, e.v);
    endtask

    task automatic chk(input logic t, input logic [1:0] a, input string tag);
        sb.push_back('{tag: tag, is_cnt: 1'b0, v: {6'b0, t, a}});
        compare();
    endtask

    task automatic cnts(input logic [2:0] c1, input logic [2:0] c2, input logic [2:0] c3, input string tag);
        sb.push_back('{tag: tag, is_cnt: 1'b1, v: {c1, c2, c3}});
        compare();
    endtask

    task automatic cyc(input logic [2:0] b, input logic m, input logic c,
                       input logic t, input logic [1:0] a, input string tag);
        bus.buzz_in = b;
        bus.mute    = m;
        bus.clr_cnt = c;
        sb.push_back('{tag: tag, is_cnt: 1'b0, v: {6'b0, t, a}});
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        bus.buzz_in = 3'b000;
        bus.mute    = 1'b0;
        bus.clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk(1'b0, 2'd0, "reset_out");
        cnts(3'd0, 3'd0, 3'd0, "reset_cnt");
        reset = 1'b0;

        for (int i = 0; i < 20; i++) cyc(3'b001, 1'b0, 1'b0, basic[i % 12], 2'd1, "basic");
        cnts(3'd1, 3'd0, 3'd0, "basic_cnt");
        cyc(3'b000, 1'b0, 1'b0, 1'b0, 2'd0, "basic_drop");

        for (int i = 0; i < 5; i++) cyc(3'b010, 1'b0, 1'b0, dropp[i], 2'd2, "drop_on");
        cyc(3'b000, 1'b0, 1'b0, 1'b0, 2'd0, "drop_idle");
        cnts(3'd1, 3'd1, 3'd0, "drop_cnt");

        for (int i = 0; i < 3; i++) cyc(3'b001, 1'b0, 1'b0, basic[i], 2'd1, "pre_ch1");
        for (int i = 0; i < 6; i++) cyc(3'b101, 1'b0, 1'b0, pre[i], 2'd3, "pre_ch3");
        repeat (2) cyc(3'b100, 1'b0, 1'b0, 1'b0, 2'd3, "pre_100");
        repeat (2) cyc(3'b101, 1'b0, 1'b0, 1'b0, 2'd3, "pre_no_return");
        cyc(3'b000, 1'b0, 1'b0, 1'b0, 2'd0, "pre_idle");
        cnts(3'd3, 3'd1, 3'd1, "pre_cnt");

        repeat (2) cyc(3'b100, 1'b0, 1'b0, 1'b1, 2'd3, "mute_pre");
        repeat (5) cyc(3'b100, 1'b1, 1'b0, 1'b0, 2'd0, "mute_hold");
        repeat (2) cyc(3'b100, 1'b0, 1'b0, 1'b1, 2'd3, "mute_restart");
        cyc(3'b000, 1'b0, 1'b0, 1'b0, 2'd0, "mute_idle");
        cnts(3'd3, 3'd1, 3'd2, "mute_cnt");
        cyc(3'b000, 1'b1, 1'b0, 1'b0, 2'd0, "mute_quiet");
        repeat (2) cyc(3'b100, 1'b1, 1'b0, 1'b0, 2'd0, "mute_edge");
        cnts(3'd3, 3'd1, 3'd3, "mute_edge_cnt");
        cyc(3'b100, 1'b0, 1'b0, 1'b1, 2'd3, "mute_release");
        cyc(3'b000, 1'b0, 1'b0, 1'b0, 2'd0, "mute_end");

        cyc(3'b000, 1'b0, 1'b1, 1'b0, 2'd0, "clr");
        cnts(3'd0, 3'd0, 3'd0, "clr_cnt");
        for (int k = 1; k <= 9; k++) begin
            cyc(3'b001, 1'b0, 1'b0, 1'b1, 2'd1, "sat_on");
            cyc(3'b000, 1'b0, 1'b0, 1'b0, 2'd0, "sat_off");
            cnts(3'(k > 7 ? 7 : k), 3'd0, 3'd0, "sat_cnt");
        end
        cyc(3'b001, 1'b0, 1'b1, 1'b1, 2'd1, "clr_edge");
        cnts(3'd0, 3'd0, 3'd0, "clr_edge_cnt");

        cyc(3'b001, 1'b0, 1'b0, 1'b1, 2'd1, "pre_rst");
        #2 reset = 1'b1;
        #1;
        chk(1'b0, 2'd0, "rst_async");
        cnts(3'd0, 3'd0, 3'd0, "rst_cnt");
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        chk(1'b1, 2'd1, "rst_restart");
        cnts(3'd1, 3'd0, 3'd0, "rst_restart_cnt");

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/alarm_tone_driver.md
Name: alarm_tone_driver

Overview:
Downstream consumer of the sensor-alarm block's three buzzer level outputs (buzzer1..buzzer3, each a one-hot pulse of about 31 cycles). Converts the active buzzer into an audible square-wave tone with a per-channel pitch and an on/off cadence. Also keeps per-channel saturating alarm-event counters for status readout. Drives the single piezo pin of the design.

Parameters:
DIV1, 50, tone half-period in clk cycles for channel 1 (>=1)
DIV2, 100, tone half-period for channel 2 (>=1)
DIV3, 200, tone half-period for channel 3 (>=1)
ON_CYC, 64, cadence on-phase length in clk cycles (>=1)
OFF_CYC, 32, cadence off-phase length in clk cycles (>=1)
CW, 8, event counter width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
buzz_in  input  3  buzzer levels from upstream; bit0=buzzer1, bit1=buzzer2, bit2=buzzer3
mute  input  1  synchronous mute; suppresses tone only
clr_cnt  input  1  synchronous clear of all event counters
tone_out  output  1  square-wave drive to the piezo
active  output  2  channel currently sounding: 0=none, 1..3=channel
event_cnt1  output  CW  rising-edge count of buzz_in[0]
event_cnt2  output  CW  rising-edge count of buzz_in[1]
event_cnt3  output  CW  rising-edge count of buzz_in[2]

Behaviour:
- Reset (async, active-high) forces: state=IDLE, tone_out=0, active=0, all event_cnt=0, divider/cadence counters=0, buzz_prev=0.
- Channel select: sel = highest set bit of buzz_in (3 > 2 > 1). Priority applies even if upstream violates one-hot.
- FSM states are IDLE, ON and OFF. All outputs are registered.
- IDLE:
  - tone_out=0, active=0.
  - If mute=0 and buzz_in!=0 at an edge: go to ON at that edge with active<=sel, tone_out<=1, div_cnt<=0, cad_cnt<=0.
  - Latency: tone_out is high in the first cycle after the edge that samples the request.
- ON:
  - div_cnt increments each cycle.
  - When div_cnt==DIVsel-1: tone_out toggles and div_cnt<=0. Tone period is 2*DIVsel cycles.
  - cad_cnt increments each cycle. When cad_cnt==ON_CYC-1: go to OFF with tone_out<=0 and cad_cnt<=0. ON lasts exactly ON_CYC cycles.
- OFF:
  - tone_out=0; active holds its value.
  - When cad_cnt==OFF_CYC-1: go back to ON (entry as from IDLE) if the latched channel is still asserted; otherwise go to IDLE.
- Drop: if buzz_in[active-1]==0 in ON or OFF, go to IDLE at the next edge with tone_out<=0 and active<=0. Drop takes precedence over cadence transitions.
- Preempt: in ON or OFF, if sel>active and the latched channel is still asserted, re-enter ON with active<=sel, tone_out<=1 and both counters cleared. A lower-priority channel never preempts.
- Drop with another channel asserted: if the latched channel drops while another channel is asserted, the next edge goes directly to ON for the new sel. There is no IDLE gap cycle.
- Mute:
  - mute=1 at any edge forces IDLE (tone_out<=0, active<=0) and holds IDLE while mute=1. Mute takes precedence over every other transition.
  - After mute falls, a still-asserted buzz_in restarts ON at the next edge.
- Event counters:
  - buzz_prev registers buzz_in. Rising edge i is buzz_in[i] & ~buzz_prev[i].
  - On a rising edge, event_cnt(i+1) increments and saturates at 2^CW-1 (no wrap). Counting is independent of mute and FSM state.
  - clr_cnt=1 clears all three counters. It beats a simultaneous increment; that edge's event is lost.
- Reset mid-tone: tone_out drops to 0 asynchronously. Counters are lost.
- Counter widths must hold max(DIVx)-1 and max(ON_CYC,OFF_CYC)-1.

Test Plan:
Bench parameters: DIV1=2, DIV2=3, DIV3=4, ON_CYC=8, OFF_CYC=4, CW=3.
- Basic tone: buzz_in=001 held 20 cycles.
  -> tone_out is 1,1,0,0,1,1,0,0 (8 cycles) then 0 for 4 cycles, then repeats; active=1 throughout; event_cnt1=1.
- Drop: buzz_in=010 for 5 cycles, then 000.
  -> tone_out is 1,1,1,0,0 then 0 from the next edge; active=0 one cycle after the drop; event_cnt2=1.
- Preempt: buzz_in=001 for 3 cycles, then 101.
  -> at the preempt edge active=3, tone_out=1, and the tone uses half-period 4; a later change to 100->101 does not return to channel 1.
- Mute: buzz_in=100 with mute=1 from cycle 2 to 6.
  -> tone_out=0 and active=0 during mute; ON restarts with tone_out=1 one edge after mute falls; event_cnt3=1 (edge counted despite mute).
- Saturation and clear: pulse buzz_in[0] 9 times.
  -> event_cnt1 = 7 (saturated).
  -> clr_cnt=1 coincident with a 10th rising edge gives event_cnt1=0.
- Async reset: assert reset mid-ON between clock edges.
  -> tone_out=0, active=0 and all counters 0 immediately; after release, held buzz_in restarts ON.
